shift_sequencer: RTL and testbench

- Sequential controller that sits directly upstream of the team's 8-bit combinational barrel shifter (ports a, dir, amt, y).
- Holds a pattern register and drives it into the shifter once per prescaled tick, then registers the shifter result back.
- Produces a "bouncing" pattern for the LED demo. When a shift would push a set bit off the edge, it reverses direction instead of shifting.
- Stops after a programmed number of bounces, on request, or when the pattern can move in neither direction.

---
 rtl/shift_sequencer.sv | 122 ++++++++++++
 tb/tb_shift_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Bouncing-pattern sequencer feeding an external zero-latency 8-bit barrel shifter.
// Steps once per prescaled tick and reverses direction instead of shifting set bits off the edge.
module shift_sequencer #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned N_BOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] seed,
  input  logic [1:0] step,
  output logic [7:0] sh_a,
  output logic       sh_dir,
  output logic [1:0] sh_amt,
  input  logic [7:0] sh_y,
  output logic [7:0] pattern,
  output logic       busy,
  output logic       done,
  output logic       stuck
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [7:0]  pattern_q;
  logic        dir_q;
  logic [1:0]  amt_q;
  logic [31:0] presc_q;
  logic [7:0]  bounce_q;
  logic        consec_q;
  logic        busy_q;
  logic        done_q;
  logic        stuck_q;

  logic [7:0]  bounce_d;
  logic [2:0]  mask_sh;
  logic [7:0]  loss_mask;
  logic        lose;
  logic        tick;

  // Mask covers the amt+1 bits that the next shift would push off the edge.
  always_comb begin
    mask_sh   = 3'd7 - {1'b0, amt_q};
    loss_mask = dir_q ? (8'hFF >> mask_sh) : (8'hFF << mask_sh);
    lose      = (pattern_q & loss_mask) != 8'h00;
    tick      = presc_q == 32'(TICK_DIV - 1);
    bounce_d  = bounce_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pattern_q <= 8'h00;
      dir_q     <= 1'b0;
      amt_q     <= 2'd0;
      presc_q   <= 32'd0;
      bounce_q  <= 8'd0;
      consec_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && (seed != 8'h00)) begin
            pattern_q <= seed;
            amt_q     <= step;
            dir_q     <= 1'b0;
            presc_q   <= 32'd0;
            bounce_q  <= 8'd0;
            consec_q  <= 1'b0;
            stuck_q   <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            presc_q <= tick ? 32'd0 : presc_q + 32'd1;
            if (tick) begin
              if (!lose) begin
                pattern_q <= sh_y;
                consec_q  <= 1'b0;
              end else begin
                dir_q    <= ~dir_q;
                bounce_q <= bounce_d;
                // Two bounces in a row means no legal move either way.
                if (consec_q) begin
                  stuck_q <= 1'b1;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
                end else if (bounce_d == 8'(N_BOUNCE)) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
                end else begin
                  consec_q <= 1'b1;
                end
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sh_a    = pattern_q;
  assign sh_dir  = dir_q;
  assign sh_amt  = amt_q;
  assign pattern = pattern_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign stuck   = stuck_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: table vectors, corner sequences and random runs against a tick-level model.
module tb_shift_sequencer;
  localparam int TICK = 4;
  localparam int NB   = 2;

  logic       clk = 1'b0;
  logic       rst_n, start, stop;
  logic [7:0] seed;
  logic [1:0] step;
  logic [7:0] sh_a, sh_y, pattern;
  logic       sh_dir, busy, done, stuck;
  logic [1:0] sh_amt;

  int total = 0;
  int bad   = 0;

  shift_sequencer #(.TICK_DIV(TICK), .N_BOUNCE(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .seed(seed), .step(step),
    .sh_a(sh_a), .sh_dir(sh_dir), .sh_amt(sh_amt), .sh_y(sh_y),
    .pattern(pattern), .busy(busy), .done(done), .stuck(stuck)
  );

  always #5 clk = ~clk;

  // Stand-in for the combinational barrel shifter.
  always_comb sh_y = sh_dir ? (sh_a >> ({1'b0, sh_amt} + 3'd1)) : (sh_a << ({1'b0, sh_amt} + 3'd1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Tick-level model: a move is legal iff shifting preserves the number of set bits.
  logic [7:0] m_pat;
  logic       m_dir, m_prev, m_done, m_stuck;
  int         m_b;

  task automatic model_tick(input logic [1:0] st);
    int k;
    logic [15:0] w;
    logic [7:0] nxt;
    k = int'(st) + 1;
    w = m_dir ? ({8'h00, m_pat} >> k) : ({8'h00, m_pat} << k);
    nxt = w[7:0];
    if ($countones(nxt) == $countones(m_pat)) begin
      m_pat  = nxt;
      m_prev = 1'b0;
    end else begin
      m_dir = ~m_dir;
      m_b++;
      if (m_prev) begin
        m_done  = 1'b1;
        m_stuck = 1'b1;
      end else if (m_b == NB) begin
        m_done = 1'b1;
      end else begin
        m_prev = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_check(input logic [7:0] s, input logic [1:0] st,
                           output int ticks, output logic [7:0] fpat, output logic fstuck);
    int c;
    m_pat = s; m_dir = 1'b0; m_b = 0; m_prev = 1'b0; m_done = 1'b0; m_stuck = 1'b0;
    seed = s; step = st; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start busy", busy, 1);
    chk("start pattern", pattern, s);
    chk("start dir", sh_dir, 0);
    chk("start amt", sh_amt, st);
    chk("start stuck", stuck, 0);
    ticks = 0;
    c = 0;
    while (!m_done && c < 400) begin
      cyc();
      c++;
      if (c % TICK == 0) begin
        model_tick(st);
        ticks++;
      end
      chk("run pattern", pattern, m_pat);
      chk("run sh_a", sh_a, m_pat);
      chk("run dir", sh_dir, m_dir);
      chk("run amt", sh_amt, st);
      chk("run busy", busy, !m_done);
      chk("run done", done, m_done);
    end
    chk("run completed within budget", m_done, 1);
    cyc();
    chk("post done", done, 0);
    chk("post busy", busy, 0);
    chk("post stuck", stuck, m_stuck);
    chk("post pattern", pattern, m_pat);
    fpat = m_pat;
    fstuck = m_stuck;
  endtask

  typedef struct {
    logic [7:0] seed;
    logic [1:0] step;
    int         ticks;
    logic [7:0] pat;
    logic       stk;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [7:0] fp;
    logic fs;

    vecs[0] = '{8'h01, 2'd0, 16, 8'h01, 1'b0};
    vecs[1] = '{8'h18, 2'd3,  2, 8'h18, 1'b1};
    vecs[2] = '{8'h03, 2'd1,  8, 8'h03, 1'b0};
    vecs[3] = '{8'h80, 2'd0,  9, 8'h01, 1'b0};
    vecs[4] = '{8'hFF, 2'd2,  2, 8'hFF, 1'b1};
    vecs[5] = '{8'h24, 2'd2,  2, 8'h24, 1'b1};
    vecs[6] = '{8'h10, 2'd1,  6, 8'h01, 1'b0};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; seed = 8'h00; step = 2'd0;
    cyc(); cyc();
    chk("reset pattern", pattern, 8'h00);
    chk("reset dir", sh_dir, 0);
    chk("reset amt", sh_amt, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset stuck", stuck, 0);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 7; i++) begin
      run_check(vecs[i].seed, vecs[i].step, t, fp, fs);
      chk($sformatf("vec%0d ticks", i), t, vecs[i].ticks);
      chk($sformatf("vec%0d final pattern", i), fp, vecs[i].pat);
      chk($sformatf("vec%0d stuck", i), fs, vecs[i].stk);
    end

    // Stop coincident with the first tick; start in RUN ignored; stuck cleared by new start.
    run_check(8'h18, 2'd3, t, fp, fs);
    seed = 8'h01; step = 2'd0; start = 1'b1;
    cyc();
    chk("restart clears stuck", stuck, 0);
    chk("restart busy", busy, 1);
    seed = 8'hAA; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start in run ignored", pattern, 8'h01);
    cyc(); cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop busy", busy, 0);
    chk("stop beats tick pattern", pattern, 8'h01);
    chk("stop no done", done, 0);
    cyc();
    chk("stop no done later", done, 0);
    chk("stop stays idle", busy, 0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop in idle", busy, 0);

    // New start after a stuck run loads the new seed; then start+stop together in RUN.
    run_check(8'h24, 2'd2, t, fp, fs);
    chk("stuck before reload", stuck, 1);
    seed = 8'h42; step = 2'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("reload pattern", pattern, 8'h42);
    chk("reload amt", sh_amt, 2);
    chk("reload stuck cleared", stuck, 0);
    seed = 8'h99; start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("start+stop busy", busy, 0);
    chk("start+stop pattern", pattern, 8'h42);

    // Reset mid-run at pattern 0x20 with start held.
    seed = 8'h01; step = 2'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5 * TICK; i++) cyc();
    chk("pre-reset pattern", pattern, 8'h20);
    rst_n = 1'b0; start = 1'b1; seed = 8'h77;
    cyc();
    chk("midrst pattern", pattern, 8'h00);
    chk("midrst busy", busy, 0);
    chk("midrst dir", sh_dir, 0);
    chk("midrst done", done, 0);
    rst_n = 1'b1; start = 1'b0;
    cyc();
    chk("after rst busy", busy, 0);
    chk("after rst pattern", pattern, 8'h00);

    // Zero seed is ignored.
    seed = 8'h00; step = 2'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("zero seed busy", busy, 0);
      chk("zero seed done", done, 0);
      chk("zero seed pattern", pattern, 8'h00);
      cyc();
    end

    for (int i = 0; i < 40; i++) begin
      logic [7:0] rs;
      logic [1:0] rst;
      rs  = 8'($urandom_range(1, 255));
      rst = 2'($urandom_range(0, 3));
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) cyc();
      run_check(rs, rst, t, fp, fs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
